// File: rtl/riscy_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscy_mem_pkg
//  Description : Shared memory-access definitions: access size encodings,
//                data-port arbiter states and the access legality check.
//  Revision    : 1.0  initial release
// ============================================================================
package riscy_mem_pkg;

   // Access size encodings as seen on the ram d_size port
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Data-port arbiter sequencing states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_t;

   // Returns 1 when an access cannot be issued to ram: a misaligned half or
   // word, or the reserved size encoding.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage : riscy_mem_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin pick. On a tie the port that was not
//                granted last wins. Purely combinational; the caller keeps
//                the last-grant history.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot winner selection; port 0 wins ties when port 1 went last
   always_comb begin
      grant = 2'b00;
      if (req0 && (!req1 || last_grant)) begin
         grant = 2'b01;
      end else if (req1) begin
         grant = 2'b10;
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the ram data port between the load/store unit
//                (port 0) and the loader/debug DMA (port 1). One access in
//                flight; round-robin grant, fixed read latency, one-cycle
//                done/err completion pulse to the winner.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
   import riscy_mem_pkg::*;
#(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   // port 0: load/store unit
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [1:0]        size0,
   input  logic              uns0,
   output logic              gnt0,
   output logic              done0,
   output logic              err0,
   output logic [DATA_W-1:0] rdata0,
   // port 1: loader / debug DMA
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [1:0]        size1,
   input  logic              uns1,
   output logic              gnt1,
   output logic              done1,
   output logic              err1,
   output logic [DATA_W-1:0] rdata1,
   // ram data port
   output logic [ADDR_W-1:0] d_addr,
   output logic [DATA_W-1:0] d_in,
   output logic [1:0]        d_size,
   output logic              u_en,
   output logic              w_en,
   input  logic [DATA_W-1:0] d_out
);

   // Last WAIT count value before the read data is due
   localparam logic [1:0] C_WAIT_LAST = 2'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

   arb_state_t        r_state;
   arb_state_t        w_next_state;

   logic              r_last_grant;
   logic              r_owner;
   logic              r_we;
   logic              r_err;
   logic [1:0]        r_wait_cnt;
   logic [ADDR_W-1:0] r_d_addr;
   logic [DATA_W-1:0] r_d_in;
   logic [1:0]        r_d_size;
   logic              r_u_en;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   logic [1:0]        w_grant;
   logic              w_arb_en;
   logic              w_take;
   logic              w_win;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [1:0]        w_sel_size;
   logic              w_sel_uns;
   logic              w_illegal;
   logic              w_rd_resp;

   rr_arb2 u_rr_arb2 (
      .req0       (req0),
      .req1       (req1),
      .last_grant (r_last_grant),
      .grant      (w_grant)
   );

   // Grants are only offered from IDLE and never while reset is asserted
   assign w_arb_en = (r_state == ST_IDLE) && !rst;
   assign w_take   = w_arb_en && (w_grant != 2'b00);
   assign w_win    = w_grant[1];

   // Request fields of the winning port
   always_comb begin
      w_sel_we    = we0;
      w_sel_addr  = addr0;
      w_sel_wdata = wdata0;
      w_sel_size  = size0;
      w_sel_uns   = uns0;
      if (w_win) begin
         w_sel_we    = we1;
         w_sel_addr  = addr1;
         w_sel_wdata = wdata1;
         w_sel_size  = size1;
         w_sel_uns   = uns1;
      end
   end

   assign w_illegal = is_misaligned(w_sel_size, w_sel_addr[1:0]);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state, grant, completion and write-enable decode
   always_comb begin
      w_next_state = r_state;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      done0        = 1'b0;
      done1        = 1'b0;
      err0         = 1'b0;
      err1         = 1'b0;
      w_en         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_take) begin
               gnt0         = w_grant[0];
               gnt1         = w_grant[1];
               w_next_state = w_illegal ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_en = r_we;
            if (r_we || (READ_LAT <= 1)) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_wait_cnt == C_WAIT_LAST) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            done0        = !r_err && !r_owner;
            done1        = !r_err &&  r_owner;
            err0         =  r_err && !r_owner;
            err1         =  r_err &&  r_owner;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Capture the winning request; ram-facing fields only load for legal ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_we         <= 1'b0;
         r_err        <= 1'b0;
         r_d_addr     <= '0;
         r_d_in       <= '0;
         r_d_size     <= 2'b00;
         r_u_en       <= 1'b0;
      end else if (w_take) begin
         r_last_grant <= w_win;
         r_owner      <= w_win;
         r_we         <= w_sel_we;
         r_err        <= w_illegal;
         if (!w_illegal) begin
            r_d_addr <= w_sel_addr;
            r_d_in   <= w_sel_wdata;
            r_d_size <= w_sel_size;
            r_u_en   <= w_sel_uns;
         end
      end
   end

   // Read-latency counter, cleared while the address is first presented
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= 2'b00;
      end else if (r_state == ST_ACCESS) begin
         r_wait_cnt <= 2'b00;
      end else if (r_state == ST_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 2'd1;
      end
   end

   assign w_rd_resp = (r_state == ST_RESP) && !r_we && !r_err;

   // Hold each port's last load result until its next read response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else if (w_rd_resp) begin
         if (r_owner) begin
            r_rdata1 <= d_out;
         end else begin
            r_rdata0 <= d_out;
         end
      end
   end

   // Load data is visible in the completion cycle, then held from the register
   assign rdata0 = (w_rd_resp && !r_owner) ? d_out : r_rdata0;
   assign rdata1 = (w_rd_resp &&  r_owner) ? d_out : r_rdata1;

   assign d_addr = r_d_addr;
   assign d_in   = r_d_in;
   assign d_size = r_d_size;
   assign u_en   = r_u_en;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed scoreboard bench for mem_arbiter. Instance A uses
//                READ_LAT=1, instance B uses READ_LAT=3; each drives a small
//                word-wide ram model with the matching read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   typedef struct {
      int           port;
      bit           err;
      bit           rd;
      logic [31:0]  data;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // instance A signals
   logic        req0_a = 0, we0_a = 0, uns0_a = 0, req1_a = 0, we1_a = 0, uns1_a = 0;
   logic [13:0] addr0_a = '0, addr1_a = '0;
   logic [31:0] wdata0_a = '0, wdata1_a = '0;
   logic [1:0]  size0_a = '0, size1_a = '0;
   logic        gnt0_a, done0_a, err0_a, gnt1_a, done1_a, err1_a;
   logic [31:0] rdata0_a, rdata1_a, d_in_a, d_out_a;
   logic [13:0] d_addr_a;
   logic [1:0]  d_size_a;
   logic        u_en_a, w_en_a;

   // instance B signals
   logic        req0_b = 0, we0_b = 0, uns0_b = 0, req1_b = 0, we1_b = 0, uns1_b = 0;
   logic [13:0] addr0_b = '0, addr1_b = '0;
   logic [31:0] wdata0_b = '0, wdata1_b = '0;
   logic [1:0]  size0_b = '0, size1_b = '0;
   logic        gnt0_b, done0_b, err0_b, gnt1_b, done1_b, err1_b;
   logic [31:0] rdata0_b, rdata1_b, d_in_b, d_out_b;
   logic [13:0] d_addr_b;
   logic [1:0]  d_size_b;
   logic        u_en_b, w_en_b;

   int   checks = 0;
   int   failures = 0;
   int   wen_cnt_a = 0;
   int   gnt_log[$];
   sb_t  sb_a[$];
   sb_t  sb_b[$];
   sb_t  ea, eb;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LAT(1)) dut_a (
      .clk(clk), .rst(rst),
      .req0(req0_a), .we0(we0_a), .addr0(addr0_a), .wdata0(wdata0_a), .size0(size0_a), .uns0(uns0_a),
      .gnt0(gnt0_a), .done0(done0_a), .err0(err0_a), .rdata0(rdata0_a),
      .req1(req1_a), .we1(we1_a), .addr1(addr1_a), .wdata1(wdata1_a), .size1(size1_a), .uns1(uns1_a),
      .gnt1(gnt1_a), .done1(done1_a), .err1(err1_a), .rdata1(rdata1_a),
      .d_addr(d_addr_a), .d_in(d_in_a), .d_size(d_size_a), .u_en(u_en_a), .w_en(w_en_a),
      .d_out(d_out_a)
   );

   mem_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LAT(3)) dut_b (
      .clk(clk), .rst(rst),
      .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .size0(size0_b), .uns0(uns0_b),
      .gnt0(gnt0_b), .done0(done0_b), .err0(err0_b), .rdata0(rdata0_b),
      .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .size1(size1_b), .uns1(uns1_b),
      .gnt1(gnt1_b), .done1(done1_b), .err1(err1_b), .rdata1(rdata1_b),
      .d_addr(d_addr_b), .d_in(d_in_b), .d_size(d_size_b), .u_en(u_en_b), .w_en(w_en_b),
      .d_out(d_out_b)
   );

   // ram models: word-wide array, registered read with 1 or 3 cycles latency
   logic [31:0] mem_a [0:63];
   logic [31:0] mem_b [0:63];
   logic [31:0] rd_a, rb1, rb2, rb3;

   always @(posedge clk) begin
      if (w_en_a) mem_a[d_addr_a[7:2]] <= d_in_a;
      rd_a <= mem_a[d_addr_a[7:2]];
      if (w_en_b) mem_b[d_addr_b[7:2]] <= d_in_b;
      rb1 <= mem_b[d_addr_b[7:2]];
      rb2 <= rb1;
      rb3 <= rb2;
   end
   assign d_out_a = rd_a;
   assign d_out_b = rb3;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_vec(input sb_t e);
      if (e.port == 0) return e.err ? 4'b0100 : 4'b1000;
      return e.err ? 4'b0001 : 4'b0010;
   endfunction

   task automatic drive(input int d, input int p, input logic we, input logic [13:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz);
      if (d == 0 && p == 0) begin req0_a = 1; we0_a = we; addr0_a = addr; wdata0_a = wd; size0_a = sz; end
      if (d == 0 && p == 1) begin req1_a = 1; we1_a = we; addr1_a = addr; wdata1_a = wd; size1_a = sz; end
      if (d == 1 && p == 0) begin req0_b = 1; we0_b = we; addr0_b = addr; wdata0_b = wd; size0_b = sz; end
      if (d == 1 && p == 1) begin req1_b = 1; we1_b = we; addr1_b = addr; wdata1_b = wd; size1_b = sz; end
   endtask

   task automatic push(input int d, input int p, input bit err, input bit rd, input logic [31:0] data);
      sb_t e;
      e.port = p; e.err = err; e.rd = rd; e.data = data;
      if (d == 0) sb_a.push_back(e); else sb_b.push_back(e);
   endtask

   // Wait (bounded) for the grant, report its cycle offset, then drop req
   task automatic wait_gnt(input int d, input int p, output int cyc);
      logic g;
      bit   found = 0;
      cyc = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         g = (d == 0) ? ((p == 0) ? gnt0_a : gnt1_a) : ((p == 0) ? gnt0_b : gnt1_b);
         if (g) found = 1; else cyc++;
      end
      check($sformatf("gnt_seen_d%0d_p%0d", d, p), 128'(found), 128'(1));
      @(posedge clk);
      #1;
      if (d == 0 && p == 0) req0_a = 0;
      if (d == 0 && p == 1) req1_a = 0;
      if (d == 1 && p == 0) req0_b = 0;
      if (d == 1 && p == 1) req1_b = 0;
   endtask

   task automatic drain(input int d);
      for (int i = 0; i < 60 && ((d == 0) ? sb_a.size() : sb_b.size()) != 0; i++) @(negedge clk);
      check($sformatf("drain_d%0d", d), 128'((d == 0) ? sb_a.size() : sb_b.size()), 128'(0));
   endtask

   // Monitor A: single grant, grant order log, completions vs scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         check("one_gnt_a", 128'(gnt0_a & gnt1_a), 128'(0));
         if (w_en_a) wen_cnt_a++;
         if (gnt0_a) gnt_log.push_back(0);
         if (gnt1_a) gnt_log.push_back(1);
         if (done0_a | err0_a | done1_a | err1_a) begin
            if (sb_a.size() == 0) begin
               check("unexpected_resp_a", 128'({done0_a, err0_a, done1_a, err1_a}), 128'(0));
            end else begin
               ea = sb_a.pop_front();
               check("resp_a", 128'({done0_a, err0_a, done1_a, err1_a}), 128'(exp_vec(ea)));
               if (ea.rd && !ea.err)
                  check("rdata_a", 128'((ea.port == 0) ? rdata0_a : rdata1_a), 128'(ea.data));
            end
         end
      end
   end

   // Monitor B: single grant, completions vs scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         check("one_gnt_b", 128'(gnt0_b & gnt1_b), 128'(0));
         if (done0_b | err0_b | done1_b | err1_b) begin
            if (sb_b.size() == 0) begin
               check("unexpected_resp_b", 128'({done0_b, err0_b, done1_b, err1_b}), 128'(0));
            end else begin
               eb = sb_b.pop_front();
               check("resp_b", 128'({done0_b, err0_b, done1_b, err1_b}), 128'(exp_vec(eb)));
               if (eb.rd && !eb.err)
                  check("rdata_b", 128'((eb.port == 0) ? rdata0_b : rdata1_b), 128'(eb.data));
            end
         end
      end
   end

   initial begin
      int c;
      int n;
      int snap;
      int pulses;

      // ---- reset state
      repeat (2) @(negedge clk);
      check("rst_a", {7'd0, gnt0_a, gnt1_a, done0_a, done1_a, err0_a, err1_a, w_en_a, u_en_a,
                      d_size_a, rdata0_a, rdata1_a, d_addr_a, d_in_a}, 128'(0));
      check("rst_b", {7'd0, gnt0_b, gnt1_b, done0_b, done1_b, err0_b, err1_b, w_en_b, u_en_b,
                      d_size_b, rdata0_b, rdata1_b, d_addr_b, d_in_b}, 128'(0));
      rst = 0;

      // ---- port 0 word write 0xfefe @0
      @(posedge clk); #1;
      drive(0, 0, 1'b1, 14'h0, 32'h0000_fefe, 2'd2);
      push(0, 0, 0, 0, 32'h0);
      @(negedge clk);
      check("t1_gnt", 128'({gnt0_a, gnt1_a, w_en_a}), 128'(3'b100));
      @(posedge clk); #1 req0_a = 0;
      @(negedge clk);
      check("t1_access", 128'({w_en_a, d_size_a, d_addr_a, d_in_a}), 128'({1'b1, 2'd2, 14'h0, 32'h0000_fefe}));
      @(negedge clk);
      check("t1_done", 128'({done0_a, w_en_a}), 128'(2'b10));
      drain(0);
      check("t1_mem0", 128'(mem_a[0]), 128'(32'h0000_fefe));

      // ---- port 1 word read @0
      @(posedge clk); #1;
      drive(0, 1, 1'b0, 14'h0, 32'h0, 2'd2);
      push(0, 1, 0, 1, 32'h0000_fefe);
      @(negedge clk);
      check("t2_gnt", 128'({gnt0_a, gnt1_a}), 128'(2'b01));
      @(posedge clk); #1 req1_a = 0;
      @(negedge clk);
      check("t2_access", 128'({w_en_a, d_addr_a}), 128'({1'b0, 14'h0}));
      @(negedge clk);
      check("t2_done", 128'({done1_a, rdata1_a}), 128'({1'b1, 32'h0000_fefe}));
      drain(0);
      repeat (3) @(negedge clk);
      check("t2_rdata_hold", 128'(rdata1_a), 128'(32'h0000_fefe));

      // ---- simultaneous requests from reset
      @(negedge clk) rst = 1;
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      drive(0, 0, 1'b1, 14'h4, 32'h0000_abba, 2'd2);
      drive(0, 1, 1'b0, 14'h4, 32'h0, 2'd2);
      push(0, 0, 0, 0, 32'h0);
      push(0, 1, 0, 1, 32'h0000_abba);
      wait_gnt(0, 0, c);
      check("t3_gnt0_cycle", 128'(c), 128'(0));
      wait_gnt(0, 1, c);
      check("t3_gnt1_cycle", 128'(c), 128'(2));
      drain(0);

      // ---- both held continuously: alternate grants
      gnt_log.delete();
      @(posedge clk); #1;
      drive(0, 0, 1'b1, 14'h10, 32'h1111_1111, 2'd2);
      drive(0, 1, 1'b1, 14'h14, 32'h2222_2222, 2'd2);
      for (int i = 0; i < 7; i++) push(0, i % 2, 0, 0, 32'h0);
      n = 0;
      for (int i = 0; i < 100 && n < 6; i++) begin
         @(negedge clk);
         if (gnt0_a || gnt1_a) n++;
      end
      check("t4_six_grants", 128'(n), 128'(6));
      @(posedge clk); #1 req1_a = 0;
      wait_gnt(0, 0, c);
      drain(0);
      check("t4_log_len", 128'(gnt_log.size()), 128'(7));
      for (int i = 0; i < gnt_log.size() && i < 7; i++)
         check($sformatf("t4_order%0d", i), 128'(gnt_log[i]), 128'(i % 2));
      check("t4_mem10", 128'(mem_a[4]), 128'(32'h1111_1111));
      check("t4_mem14", 128'(mem_a[5]), 128'(32'h2222_2222));

      // ---- illegal accesses: misaligned half write, reserved size read
      snap = wen_cnt_a;
      @(posedge clk); #1;
      drive(0, 0, 1'b1, 14'h3, 32'hdead_beef, 2'd1);
      push(0, 0, 1, 0, 32'h0);
      wait_gnt(0, 0, c);
      drain(0);
      @(posedge clk); #1;
      drive(0, 0, 1'b0, 14'h8, 32'h0, 2'd3);
      push(0, 0, 1, 1, 32'h0);
      wait_gnt(0, 0, c);
      drain(0);
      check("t5_no_wen", 128'(wen_cnt_a), 128'(snap));
      check("t5_mem0", 128'(mem_a[0]), 128'(32'h0000_fefe));

      // ---- READ_LAT=3: reset during WAIT, then a clean read
      @(posedge clk); #1;
      drive(1, 0, 1'b1, 14'h20, 32'hcafe_f00d, 2'd2);
      push(1, 0, 0, 0, 32'h0);
      wait_gnt(1, 0, c);
      drain(1);
      @(posedge clk); #1;
      drive(1, 1, 1'b0, 14'h20, 32'h0, 2'd2);
      wait_gnt(1, 1, c);
      @(negedge clk);
      check("t6_access", 128'({w_en_b, d_addr_b}), 128'({1'b0, 14'h20}));
      @(posedge clk);
      #2 rst = 1;
      #1;
      check("t6_rst_async", {7'd0, gnt0_b, gnt1_b, done0_b, done1_b, err0_b, err1_b, w_en_b, u_en_b,
                             d_size_b, rdata0_b, rdata1_b, d_addr_b, d_in_b}, 128'(0));
      @(posedge clk);
      @(negedge clk) rst = 0;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (done0_b | done1_b | err0_b | err1_b) pulses++;
      end
      check("t6_no_resp", 128'(pulses), 128'(0));
      @(posedge clk); #1;
      drive(1, 1, 1'b0, 14'h20, 32'h0, 2'd2);
      push(1, 1, 0, 1, 32'hcafe_f00d);
      wait_gnt(1, 1, c);
      check("t6_gnt_cycle", 128'(c), 128'(0));
      repeat (3) @(negedge clk);
      check("t6_not_yet", 128'(done1_b), 128'(0));
      @(negedge clk);
      check("t6_done", 128'({done1_b, rdata1_b}), 128'({1'b1, 32'hcafe_f00d}));
      drain(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
